// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and the fetch sequencer state encoding.
// Width and reset-vector values here are the defaults the fetch blocks are built with.
package mips_pkg;

  localparam int          MIPS_ADDR_W       = 32;
  localparam int          MIPS_DATA_W       = 32;
  localparam logic [31:0] MIPS_RESET_VECTOR = 32'h0000_0000;
  localparam int          MIPS_PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// Architectural PC register: synchronous reset to the reset vector, loads d when we is high.
module pc_reg #(
  parameter int                ADDR_W       = mips_pkg::MIPS_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(mips_pkg::MIPS_RESET_VECTOR)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= RESET_VECTOR;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs the req/ack handshake to IMEM and
// presents fetched instructions to decode, applying jump/branch redirects and decode stall.
module pc_fetch_sequencer #(
  parameter int                ADDR_W       = mips_pkg::MIPS_ADDR_W,
  parameter int                DATA_W       = mips_pkg::MIPS_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(mips_pkg::MIPS_RESET_VECTOR),
  parameter int                PC_STEP      = mips_pkg::MIPS_PC_STEP
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
);

  import mips_pkg::*;

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;

  logic              pc_we;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              redirect;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] pc_inc;

  pc_reg #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .CLK(CLK),
    .RST(RST),
    .we (pc_we),
    .d  (pc_d),
    .q  (pc_q)
  );

  // Jump outranks branch; redirect targets are always word aligned.
  always_comb begin
    redirect  = jump | branch_taken;
    redir_tgt = (jump ? jump_target : branch_target) & ~ADDR_W'(3);
    pc_inc    = pc_q + ADDR_W'(PC_STEP);
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pend_d     = pend_q;
    pc_we      = 1'b0;
    pc_d       = pc_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        valid_d = 1'b0;
        if (redirect) begin
          pc_we  = 1'b1;
          pc_d   = redir_tgt;
          addr_d = redir_tgt;
        end else begin
          addr_d = pc_q;
        end
      end

      FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (imem_ack) begin
            pc_we  = 1'b1;
            pc_d   = redir_tgt;
            addr_d = redir_tgt;
          end else begin
            // The outstanding request must complete untouched; remember where to go after it.
            pend_d  = redir_tgt;
            state_d = FLUSH;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_we      = 1'b1;
          pc_d       = pc_inc;
          if (stall) begin
            state_d = HOLD;
            req_d   = 1'b0;
          end else begin
            addr_d = pc_inc;
          end
        end else begin
          valid_d = valid_q & stall;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_we   = 1'b1;
          pc_d    = redir_tgt;
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = redir_tgt;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end

      FLUSH: begin
        valid_d = 1'b0;
        if (imem_ack) begin
          pc_we   = 1'b1;
          pc_d    = redirect ? redir_tgt : pend_q;
          addr_d  = redirect ? redir_tgt : pend_q;
          state_d = FETCH;
        end else if (redirect) begin
          pend_d = redir_tgt;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_VECTOR;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pend_q     <= pend_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: an IMEM responder with random wait states,
// an instruction-stream reference model feeding an expected queue, and a negedge monitor.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] branch_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;

  int total = 0;
  int bad = 0;

  pc_fetch_sequencer dut (
    .CLK          (CLK),
    .RST          (RST),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc           (pc)
  );

  always #5 CLK = ~CLK;

  // Values seen at the previous negedge, i.e. what the DUT sees at the next posedge.
  bit          s_rst = 1'b1;
  bit          s_stall, s_jump, s_branch, s_ack, s_req;
  logic [31:0] s_jt, s_bt, s_addr;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       exp_q[$];
  item_t       last_item;
  logic [31:0] m_pc = '0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_tgt;
  bit          m_discard, m_vld, m_held, m_fresh, m_acked;
  bit          m_rst_edge, m_prev_rst = 1'b1, m_first;
  int          n_deliv = 0;

  int          wfix = 0;
  int          wleft = 0;
  bit          busy = 1'b0;
  bit          r_done;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit j, input bit b,
                               input logic [31:0] jt, input logic [31:0] bt, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      RST           = r;
      stall         = s;
      jump          = j;
      branch_taken  = b;
      jump_target   = jt;
      branch_target = bt;
    end
  endtask

  // Reference model: tracks the architectural PC and the instruction stream decode should see.
  always @(posedge CLK) begin
    m_acked = s_req && s_ack;
    m_tgt   = (s_jump ? s_jt : s_bt) & 32'hFFFF_FFFC;
    m_first = 1'b0;
    if (s_rst) begin
      m_pc       = '0;
      m_discard  = 1'b0;
      m_vld      = 1'b0;
      m_held     = 1'b0;
      m_fresh    = 1'b0;
      m_rst_edge = 1'b1;
      exp_q.delete();
    end else begin
      m_rst_edge = 1'b0;
      m_first    = m_prev_rst;
      if (m_acked && !m_discard) checkOutput("fetch_addr", s_addr, m_pc);
      if (s_jump || s_branch) begin
        m_vld  = 1'b0;
        m_held = 1'b0;
        if (s_req && !m_acked) begin
          m_discard = 1'b1;
          m_pend    = m_tgt;
        end else begin
          m_discard = 1'b0;
          m_pc      = m_tgt;
        end
      end else if (m_acked) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_pc      = m_pend;
          m_vld     = 1'b0;
        end else begin
          exp_q.push_back('{pc: m_pc, ins: m_pc ^ XOR_KEY});
          m_fresh = 1'b1;
          m_vld   = 1'b1;
          m_held  = s_stall;
          m_pc    = m_pc + 32'd4;
        end
      end else if (m_held) begin
        if (!s_stall) begin
          m_vld  = 1'b0;
          m_held = 1'b0;
        end
      end else begin
        m_vld = m_vld && s_stall;
      end
    end
    m_prev_rst = s_rst;
  end

  // IMEM responder: each new request waits wfix cycles, or a random 0..3 when wfix < 0.
  always @(posedge CLK) begin
    r_done = s_rst || (s_req && s_ack);
    #1;
    if (r_done) busy = 1'b0;
    if (imem_req && !busy) begin
      busy  = 1'b1;
      wleft = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
    end
    if (busy && imem_req && wleft == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ XOR_KEY;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (busy && wleft > 0) wleft--;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge CLK) begin
    if (m_rst_edge) begin
      checkOutput("rst_req", imem_req, 1'b0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_valid", instr_valid, 1'b0);
      checkOutput("rst_instr", instr, 32'h0);
      checkOutput("rst_instr_pc", instr_pc, 32'h0);
      checkOutput("rst_pc", pc, 32'h0);
    end else begin
      checkOutput("instr_valid", instr_valid, m_vld);
      checkOutput("pc", pc, m_pc);
      if (m_first) begin
        checkOutput("first_req", imem_req, 1'b1);
        checkOutput("first_addr", imem_addr, m_pc);
      end
      if (m_held) checkOutput("hold_req", imem_req, 1'b0);
      if (!s_rst && s_req && !s_ack) begin
        checkOutput("req_held", imem_req, 1'b1);
        checkOutput("addr_stable", imem_addr, s_addr);
      end
      if (m_fresh) begin
        m_fresh = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL scoreboard: got empty queue expected an instruction");
        end else begin
          last_item = exp_q.pop_front();
          n_deliv++;
          checkOutput("instr", instr, last_item.ins);
          checkOutput("instr_pc", instr_pc, last_item.pc);
        end
      end else if (m_vld) begin
        checkOutput("frozen_instr", instr, last_item.ins);
        checkOutput("frozen_instr_pc", instr_pc, last_item.pc);
      end
    end
    s_rst    = RST;
    s_stall  = stall;
    s_jump   = jump;
    s_branch = branch_taken;
    s_jt     = jump_target;
    s_bt     = branch_target;
    s_ack    = imem_ack;
    s_req    = imem_req;
    s_addr   = imem_addr;
  end

  initial begin
    logic [31:0] jt, bt;
    wfix = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 12);
    wfix = 3;
    applyStimulus(0, 0, 0, 0, 0, 0, 16);
    applyStimulus(0, 0, 0, 1, 0, 32'h0000_0103, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 10);
    applyStimulus(0, 0, 1, 1, 32'h0000_0200, 32'h0000_0300, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 10);
    wfix = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 0, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 5);
    applyStimulus(0, 0, 1, 0, 32'hFFFF_FFFC, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    wfix = 3;
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 6);
    wfix = -1;
    for (int i = 0; i < 800; i++) begin
      jt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
      bt = $urandom;
      applyStimulus($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 6, jt, bt, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 6);
    @(negedge CLK);
    #1;
    checkOutput("delivered_enough", (n_deliv >= 60), 1'b1);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
